// File: rtl/target_generator.sv
// Target generator for the snake game: holds the food position, counts hits and
// relocates the target to a pseudo-random legal cell after each new hit.
`timescale 1ns/1ps
module target_generator #(
    parameter int MaxX     = 159,
    parameter int MaxY     = 119,
    parameter int InitX    = 40,
    parameter int InitY    = 30,
    parameter int WinScore = 10,
    parameter int MaxTries = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  MSM_State,
    input  logic        REACHED_TARGET,
    output logic [14:0] TARGET_ADDR,
    output logic        TARGET_VALID,
    output logic [3:0]  SCORE,
    output logic        WIN
);

    localparam int            RW        = (MaxTries > 1) ? $clog2(MaxTries) : 1;
    localparam logic [RW-1:0] LAST_TRY  = RW'(MaxTries - 1);
    localparam logic [7:0]    MAX_X     = 8'(MaxX);
    localparam logic [6:0]    MAX_Y     = 7'(MaxY);
    localparam logic [14:0]   INIT_ADDR = {8'(InitX), 7'(InitY)};
    localparam logic [3:0]    WIN_SCORE = 4'(WinScore);

    typedef enum logic {
        READY = 1'b0,
        GEN   = 1'b1
    } state_t;

    state_t        state_r;
    logic [7:0]    lfsr_x_r;
    logic [6:0]    lfsr_y_r;
    logic [RW-1:0] retry_r;
    logic          reached_d_r;

    logic          hit_s;
    logic          cand_ok_s;
    logic [14:0]   cand_s;
    logic [14:0]   fallback_s;

    // x^8+x^6+x^5+x^4+1, shifting towards the MSB
    function automatic logic [7:0] lfsr_x_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    // x^7+x^6+1, shifting towards the MSB
    function automatic logic [6:0] lfsr_y_next(input logic [6:0] y);
        return {y[5:0], y[6] ^ y[5]};
    endfunction

    // Folded placement inside 128x64; nudges X by one to avoid repeating the target
    function automatic logic [14:0] fallback_addr(input logic [7:0] x, input logic [6:0] y,
                                                  input logic [14:0] cur);
        logic [7:0] fx;
        logic [6:0] fy;
        fx = {1'b0, x[6:0]};
        fy = {1'b0, y[5:0]};
        if ({fx, fy} == cur) begin
            fx = fx + 8'd1;
        end else begin
            fx = fx;
        end
        return {fx, fy};
    endfunction

    // Hit qualification and candidate evaluation
    always_comb begin
        hit_s      = REACHED_TARGET & ~reached_d_r & (MSM_State == 2'b01) & ~WIN & (state_r == READY);
        cand_s     = {lfsr_x_r, lfsr_y_r};
        cand_ok_s  = (lfsr_x_r <= MAX_X) && (lfsr_y_r <= MAX_Y) && (cand_s != TARGET_ADDR);
        fallback_s = fallback_addr(lfsr_x_r, lfsr_y_r, TARGET_ADDR);
    end

    // Control FSM, free-running LFSRs, score and target registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r      <= READY;
            lfsr_x_r     <= 8'hB3;
            lfsr_y_r     <= 7'h5A;
            retry_r      <= '0;
            reached_d_r  <= 1'b0;
            TARGET_ADDR  <= INIT_ADDR;
            TARGET_VALID <= 1'b1;
            SCORE        <= 4'd0;
            WIN          <= 1'b0;
        end else begin
            lfsr_x_r    <= lfsr_x_next(lfsr_x_r);
            lfsr_y_r    <= lfsr_y_next(lfsr_y_r);
            reached_d_r <= REACHED_TARGET;
            case (state_r)
                READY: begin
                    if (hit_s) begin
                        SCORE        <= (SCORE < WIN_SCORE) ? SCORE + 4'd1 : SCORE;
                        WIN          <= ((SCORE + 4'd1) == WIN_SCORE);
                        TARGET_VALID <= 1'b0;
                        retry_r      <= '0;
                        state_r      <= GEN;
                    end else begin
                        state_r <= READY;
                    end
                end
                GEN: begin
                    if (cand_ok_s) begin
                        TARGET_ADDR  <= cand_s;
                        TARGET_VALID <= 1'b1;
                        state_r      <= READY;
                    end else if (retry_r == LAST_TRY) begin
                        TARGET_ADDR  <= fallback_s;
                        TARGET_VALID <= 1'b1;
                        state_r      <= READY;
                    end else begin
                        retry_r <= retry_r + RW'(1);
                        state_r <= GEN;
                    end
                end
                default: begin
                    TARGET_VALID <= 1'b1;
                    state_r      <= READY;
                end
            endcase
            // Idle clears the game result; a generation in flight still completes
            if (MSM_State == 2'b00) begin
                SCORE <= 4'd0;
                WIN   <= 1'b0;
            end else begin
                WIN <= WIN | ((state_r == READY) && hit_s && ((SCORE + 4'd1) == WIN_SCORE));
            end
        end
    end

endmodule
